// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage buffers: occupancy encoding and perf counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } pipe_occ_e;

    localparam int unsigned PERF_CNT_W = 32;

    // Saturating increment; holds at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Enable register with asynchronous active-low clear; holds one {data, pc} entry.
module pipe_entry_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register: valid/ready handshake over a 2-entry skid buffer.
// Optional perf counters are built when PIPE_STAGE_BUF_PERF_EN is defined.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PC_W       = 32,
    parameter bit          FLUSH_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [PC_W-1:0]       in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [PC_W-1:0]       out_pc,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
);

    localparam int unsigned ENTRY_W = DATA_W + PC_W;

    pipe_occ_e          state_q;
    logic               push;
    logic               pop;
    logic               main_en;
    logic               skid_en;
    logic [ENTRY_W-1:0] main_d;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;

    // Ready depends only on registered occupancy, so no ready path crosses stages.
    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY) & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = {in_data, in_pc};
        if (!flush) begin
            unique case (state_q)
                OCC_EMPTY: main_en = push;
                OCC_ONE: begin
                    main_en = push & pop;
                    skid_en = push & ~pop;
                end
                OCC_FULL: begin
                    main_en = pop;
                    main_d  = skid_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OCC_EMPTY;
        end else if (flush) begin
            state_q <= OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: if (push) state_q <= OCC_ONE;
                OCC_ONE: begin
                    if (push && !pop) begin
                        state_q <= OCC_FULL;
                    end else if (pop && !push) begin
                        state_q <= OCC_EMPTY;
                    end
                end
                OCC_FULL:  if (pop) state_q <= OCC_ONE;
                default:   state_q <= OCC_EMPTY;
            endcase
        end
    end

    pipe_entry_reg #(
        .WIDTH(ENTRY_W)
    ) u_main (
        .clk(clk),
        .rst(rst),
        .en (main_en),
        .d  (main_d),
        .q  (main_q)
    );

    pipe_entry_reg #(
        .WIDTH(ENTRY_W)
    ) u_skid (
        .clk(clk),
        .rst(rst),
        .en (skid_en),
        .d  ({in_data, in_pc}),
        .q  (skid_q)
    );

    always_comb begin
        if (FLUSH_ZERO && !out_valid) begin
            out_data = '0;
            out_pc   = '0;
        end else begin
            out_data = main_q[ENTRY_W-1:PC_W];
            out_pc   = main_q[PC_W-1:0];
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q;
    logic [PERF_CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (flush && (state_q != OCC_EMPTY)) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf; inputs change and outputs are sampled near negedge.
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_pc;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PIPE_STAGE_BUF_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
    localparam logic [31:0] EXP_FLUSH = 32'd1;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

    pipe_stage_buf #(
        .DATA_W    (32),
        .PC_W      (32),
        .FLUSH_ZERO(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_pc    (in_pc),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_pc   (out_pc),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_data  = data_of(pc);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
        n_checks++; if (stall_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_stall_cnt: got %h want 0", stall_cnt); end
        n_checks++; if (flush_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_flush_cnt: got %h want 0", flush_cnt); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(4 * i);
            drive(1'b1, exp_pc);
            @(negedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, exp_pc); end
            n_checks++; if (out_data !== data_of(exp_pc)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, data_of(exp_pc)); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
        end
        drive(1'b0, 32'h0);
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL stream_drain_zero: got %h want 0", out_data); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'hA0);
        @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
        n_checks++; if (out_pc !== 32'hA0) begin n_fail++; $display("FAIL bp_pc_one: got %h want a0", out_pc); end
        drive(1'b1, 32'hA4);
        @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        n_checks++; if (out_pc !== 32'hA0) begin n_fail++; $display("FAIL bp_pc_full: got %h want a0", out_pc); end
        drive(1'b1, 32'hA8);
        @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold: got %b want 0", in_ready); end
        n_checks++; if (out_pc !== 32'hA0) begin n_fail++; $display("FAIL bp_pc_hold: got %h want a0", out_pc); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_pc !== 32'hA0) begin n_fail++; $display("FAIL bp_drain0: got %h want a0", out_pc); end
        @(negedge clk);
        #1;
        n_checks++; if (out_pc !== 32'hA4) begin n_fail++; $display("FAIL bp_drain1: got %h want a4", out_pc); end
        n_checks++; if (out_data !== data_of(32'hA4)) begin n_fail++; $display("FAIL bp_drain1_data: got %h want %h", out_data, data_of(32'hA4)); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_reopen: got %b want 1", in_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (out_pc !== 32'hA8) begin n_fail++; $display("FAIL bp_drain2: got %h want a8", out_pc); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain2_valid: got %b want 1", out_valid); end
        drive(1'b0, 32'h0);
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'hB0);
        @(negedge clk);
        drive(1'b1, 32'hB4);
        @(negedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_full: got %b want 0", in_ready); end
        flush = 1'b1;
        drive(1'b1, 32'h200);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_mask_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL flush_mask_data: got %h want 0", out_data); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL flush_mask_pc: got %h want 0", out_pc); end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_absent: got %b want 0", out_valid); end
        // Flush in ONE while a push is acceptable: the push must be dropped too.
        out_ready = 1'b0;
        drive(1'b1, 32'hC0);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'hC4);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one_push: got %b want 0", out_valid); end
    endtask

    task automatic test_push_pop_one();
        out_ready = 1'b0;
        drive(1'b1, 32'h10);
        @(negedge clk);
        drive(1'b1, 32'h14);
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_pc !== 32'h10) begin n_fail++; $display("FAIL pp_head: got %h want 10", out_pc); end
        @(negedge clk);
        drive(1'b0, 32'h0);
        #1;
        n_checks++; if (out_pc !== 32'h14) begin n_fail++; $display("FAIL pp_next: got %h want 14", out_pc); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pp_still_one: got %b want 1", in_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_full();
        out_ready = 1'b0;
        drive(1'b1, 32'h100);
        @(negedge clk);
        drive(1'b1, 32'h104);
        @(negedge clk);
        drive(1'b0, 32'h0);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmf_full: got %b want 0", in_ready); end
        n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL rmf_head: got %h want 100", out_pc); end
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_ready: got %b want 1", in_ready); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rmf_pc: got %h want 0", out_pc); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 32'h300);
        @(negedge clk);
        drive(1'b0, 32'h0);
        #1;
        n_checks++; if (out_pc !== 32'h300) begin n_fail++; $display("FAIL rmf_first_push: got %h want 300", out_pc); end
        @(negedge clk);
    endtask

    task automatic test_perf();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (stall_cnt !== 32'h0) begin n_fail++; $display("FAIL perf_rst_stall: got %h want 0", stall_cnt); end
        n_checks++; if (flush_cnt !== 32'h0) begin n_fail++; $display("FAIL perf_rst_flush: got %h want 0", flush_cnt); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h400);
        @(negedge clk);
        drive(1'b0, 32'h0);
        repeat (5) @(negedge clk);
        #1;
        n_checks++; if (stall_cnt !== EXP_STALL) begin n_fail++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt, EXP_STALL); end
        n_checks++; if (flush_cnt !== 32'h0) begin n_fail++; $display("FAIL perf_flush_pre: got %0d want 0", flush_cnt); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++; if (stall_cnt !== EXP_STALL) begin n_fail++; $display("FAIL perf_stall_post: got %0d want %0d", stall_cnt, EXP_STALL); end
        n_checks++; if (flush_cnt !== EXP_FLUSH) begin n_fail++; $display("FAIL perf_flush: got %0d want %0d", flush_cnt, EXP_FLUSH); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++; if (flush_cnt !== EXP_FLUSH) begin n_fail++; $display("FAIL perf_flush_empty: got %0d want %0d", flush_cnt, EXP_FLUSH); end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_push_pop_one();
        test_reset_mid_full();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register, successor to the fixed IF/ID latch. Usable between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces load/stall gating with a valid/ready handshake backed by a 2-entry skid buffer. Throughput is 1 transfer/cycle, and in_ready is fully registered, so there is no combinational ready path between stages.
- Flush (taken branch or redirect) drops all held entries and masks the output in the same cycle.

Parameters:
- DATA_W, 32, payload width (instruction or control bundle; RVFI packet may be concatenated in).
- PC_W, 32, width of the pc side-channel.
- FLUSH_ZERO, 1, if 1 then out_data/out_pc read 0 whenever out_valid=0; if 0 they hold the last value.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream has a payload
- in_ready  out  1  buffer can accept (registered)
- in_data  in  DATA_W  upstream payload
- in_pc  in  PC_W  upstream pc
- flush  in  1  drop all entries (true branch / redirect)
- out_valid  out  1  payload available downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_pc  out  PC_W  head pc
- stall_cnt  out  32  perf: backpressure cycles (see Optional Feature)
- flush_cnt  out  32  perf: flushes that dropped a valid entry

Behaviour:
- Storage: main entry (head) and skid entry. Each holds {data, pc}.
- Occupancy state: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid). Encoding is 2 bits, and the value 3 is illegal and recovers to EMPTY.
- Events: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != FULL). It is a function of the registered state only.
- out_valid = (state != EMPTY) & ~flush.
- Transitions without flush:
  - EMPTY + push: write to main, go to ONE.
  - ONE + push & ~pop: write to skid, go to FULL.
  - ONE + push & pop: overwrite main, stay ONE.
  - ONE + pop & ~push: go to EMPTY.
  - FULL + pop: skid moves to main, go to ONE. Push is impossible because in_ready=0.
  - Otherwise hold.
- Latency: a payload accepted at edge N is visible on out_* during cycle N+1.
- Ordering is strictly FIFO. No payload is duplicated or dropped except by flush.
- flush=1:
  - out_valid forced 0 combinationally in that cycle. With FLUSH_ZERO=1, out_data/out_pc also read 0.
  - At the next edge, state goes to EMPTY. A push in the same cycle is discarded. A pop cannot occur.
  - flush dominates push and pop.
- Reset (rst=0, asynchronous, any time, including mid-transfer):
  - state = EMPTY, and main/skid data and pc cleared to 0.
  - Resulting outputs: out_valid=0, in_ready=1, out_data=0, out_pc=0, stall_cnt=0, flush_cnt=0.
  - Deassertion is sampled on the next rising edge. The first push is possible in the cycle after release.
- Data registers load only on push or skid-to-main move. They are not reloaded on idle cycles.

Optional Feature:
- Macro: PIPE_STAGE_BUF_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - flush_cnt increments each cycle with flush & (state != EMPTY).
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: no counter flops. stall_cnt and flush_cnt are tied to 0 and the ports remain present.

Decomposition:
- Extend rv32i_types, or add a new package pipe_pkg, with:
  - the occupancy enum pipe_occ_e {OCC_EMPTY, OCC_ONE, OCC_FULL};
  - localparam PERF_CNT_W = 32.
- Payload typedefs (RVFIMonPacket and stage bundles) stay in rv32i_types. Callers size DATA_W with $bits().
- One natural sub-module: pipe_entry_reg, a WIDTH-parameterised enable register with async active-low clear. It is instantiated twice, for main and skid.
- Counters stay inline under the macro.

Test Plan:
- Reset mid-FULL: fill with pc 0x100 and 0x104, pulse rst=0 asynchronously between edges. Required: out_valid=0, in_ready=1 and out_pc=0 immediately, before any edge.
- Streaming: out_ready=1, push pc 0x0,0x4,0x8,0xC on consecutive cycles. Required: out_pc 0x0,0x4,0x8,0xC on cycles 1-4, and in_ready stays 1.
- Backpressure: out_ready=0, push 0xA0,0xA4,0xA8. Required: in_ready=0 after the second push, and 0xA8 is held upstream. Raising out_ready then yields 0xA0,0xA4,0xA8 in order with no loss.
- Flush with simultaneous push in FULL→ONE: state FULL, flush=1, in_valid=1 (pc 0x200). Required: out_valid=0 and out_data=0 that cycle; next cycle state EMPTY and 0x200 absent.
- Push+pop in ONE: main=0x10, push 0x14 while out_ready=1. Required: next cycle out_pc=0x14 and state ONE.
- PERF_EN: 5 cycles of out_valid & ~out_ready, then flush with 1 entry held. Required: stall_cnt=5, flush_cnt=1. A flush while EMPTY leaves flush_cnt=1.
